// File: rtl/data_memory_ctrl.sv
// Data-memory stage behind the core's dm_* port group: one load or store at a time,
// each taking LATENCY wait states, with busy/done/err handshake back to the core.
module data_memory_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] read_address_to_dm,
  input  logic [31:0] write_address_to_dm,
  input  logic [31:0] data_to_dm,
  output logic [31:0] data_from_dm,
  output logic        dm_busy,
  output logic        dm_done,
  output logic        dm_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_write_q, op_write_d;
  logic        err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;
  logic [31:0] sel_addr;

  logic [31:0] mem [DEPTH];

  assign sel_addr = dm_write ? write_address_to_dm : read_address_to_dm;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    err_d      = err_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dm_read && dm_write) begin
          // Conflicting request: skip the wait and report it as rejected.
          err_d   = 1'b1;
          state_d = RESP;
        end else if (dm_read ^ dm_write) begin
          op_write_d = dm_write;
          idx_d      = sel_addr[AW+1:2];
          wdata_d    = data_to_dm;
          err_d      = (sel_addr[1:0] != 2'b00) || (sel_addr[31:AW+2] != '0);
          cnt_d      = 4'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (op_write_q) begin
            mem_we = !err_q;
          end else begin
            rdata_d = err_q ? '0 : mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is deliberately outside the reset domain; an abort never reaches mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign data_from_dm = rdata_q;
  assign dm_busy      = (state_q == WAIT);
  assign dm_done      = (state_q == RESP);
  assign dm_err       = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: latency, store/load, rejects, ignored requests, reset abort.
module tb_data_memory_ctrl;

  localparam int L = 2;

  logic        clk;
  logic        reset;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] read_address_to_dm;
  logic [31:0] write_address_to_dm;
  logic [31:0] data_to_dm;
  logic [31:0] data_from_dm;
  logic        dm_busy;
  logic        dm_done;
  logic        dm_err;

  int checks;
  int errors;

  data_memory_ctrl #(
    .DEPTH  (256),
    .AW     (8),
    .LATENCY(L)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dm_read            (dm_read),
    .dm_write           (dm_write),
    .read_address_to_dm (read_address_to_dm),
    .write_address_to_dm(write_address_to_dm),
    .data_to_dm         (data_to_dm),
    .data_from_dm       (data_from_dm),
    .dm_busy            (dm_busy),
    .dm_done            (dm_done),
    .dm_err             (dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and records what the DUT shows until dm_done (bounded wait).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int busy_n, output int done_at,
                        output logic err_o, output logic [31:0] dout);
    @(negedge clk);
    dm_read = rd;
    dm_write = wr;
    read_address_to_dm = addr;
    write_address_to_dm = addr;
    data_to_dm = data;
    @(posedge clk);
    #1;
    dm_read = 1'b0;
    dm_write = 1'b0;
    busy_n = 0;
    done_at = -1;
    err_o = 1'b0;
    dout = '0;
    for (int i = 0; i < 20; i++) begin
      if (dm_busy) busy_n++;
      if (dm_done) begin
        done_at = i;
        err_o = dm_err;
        dout = data_from_dm;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({dm_busy, dm_done, dm_err} !== 3'b000 || data_from_dm !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b data=%h, want 0/0/0/0",
               dm_busy, dm_done, dm_err, data_from_dm);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dm_busy, dm_done, dm_err} !== 3'b000 || data_from_dm !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b err=%b data=%h, want 0/0/0/0",
               dm_busy, dm_done, dm_err, data_from_dm);
    end
  endtask

  task automatic test_store_load;
    int b, d;
    logic e;
    logic [31:0] o;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, b, d, e, o);
    checks++;
    if (b !== L || d !== L || e !== 1'b0) begin
      errors++;
      $display("FAIL store_timing: got busy=%0d done_at=%0d err=%b, want %0d/%0d/0", b, d, e, L, L);
    end
    checks++;
    if (o !== 32'h0) begin
      errors++;
      $display("FAIL store_keeps_data: got %h want 00000000", o);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, b, d, e, o);
    checks++;
    if (d !== L || e !== 1'b0 || o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_0x10: got done_at=%0d err=%b data=%h, want %0d/0/deadbeef", d, e, o, L);
    end
    checks++;
    if (data_from_dm !== 32'hDEADBEEF || dm_done !== 1'b0) begin
      errors++;
      $display("FAIL load_hold: got data=%h done=%b, want deadbeef/0", data_from_dm, dm_done);
    end
  endtask

  task automatic test_boundary;
    int b, d;
    logic e;
    logic [31:0] o;
    access(1'b0, 1'b1, 32'h3FC, 32'h12345678, b, d, e, o);
    access(1'b1, 1'b0, 32'h3FC, 32'h0, b, d, e, o);
    checks++;
    if (e !== 1'b0 || o !== 32'h12345678) begin
      errors++;
      $display("FAIL load_top_index: got err=%b data=%h, want 0/12345678", e, o);
    end
    access(1'b1, 1'b0, 32'h400, 32'h0, b, d, e, o);
    checks++;
    if (b !== L || d !== L || e !== 1'b1 || o !== 32'h0) begin
      errors++;
      $display("FAIL load_overflow: got busy=%0d done_at=%0d err=%b data=%h, want %0d/%0d/1/0",
               b, d, e, o, L, L);
    end
  endtask

  task automatic test_misaligned;
    int b, d;
    logic e;
    logic [31:0] o;
    access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, b, d, e, o);
    checks++;
    if (b !== L || d !== L || e !== 1'b1 || o !== 32'h0) begin
      errors++;
      $display("FAIL store_misaligned: got busy=%0d done_at=%0d err=%b data=%h, want %0d/%0d/1/0",
               b, d, e, o, L, L);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, b, d, e, o);
    checks++;
    if (e !== 1'b0 || o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_after_misaligned: got err=%b data=%h, want 0/deadbeef", e, o);
    end
  endtask

  task automatic test_illegal_and_ignored;
    int b, d, dones;
    logic e;
    logic [31:0] o;
    access(1'b1, 1'b1, 32'h10, 32'h11111111, b, d, e, o);
    checks++;
    if (b !== 0 || d !== 0 || e !== 1'b1 || o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL both_requests: got busy=%0d done_at=%0d err=%b data=%h, want 0/0/1/deadbeef",
               b, d, e, o);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, b, d, e, o);
    checks++;
    if (o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_after_both: got %h want deadbeef", o);
    end
    @(negedge clk);
    dm_write = 1'b1;
    write_address_to_dm = 32'h30;
    data_to_dm = 32'h55AA00FF;
    @(posedge clk);
    #1;
    dones = 0;
    for (int i = 0; i < L + 4; i++) begin
      if (dm_done) dones++;
      if (i < L) begin
        dm_read = i[0];
        dm_write = ~i[0];
        write_address_to_dm = 32'h40;
        read_address_to_dm = 32'h400;
        data_to_dm = 32'(i);
      end else begin
        dm_read = 1'b0;
        dm_write = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL toggle_in_wait: got %0d done pulses, want 1", dones);
    end
    access(1'b1, 1'b0, 32'h30, 32'h0, b, d, e, o);
    checks++;
    if (e !== 1'b0 || o !== 32'h55AA00FF) begin
      errors++;
      $display("FAIL latched_store: got err=%b data=%h, want 0/55aa00ff", e, o);
    end
  endtask

  task automatic test_reset_abort;
    int b, d, dones;
    logic e;
    logic [31:0] o;
    access(1'b0, 1'b1, 32'h20, 32'h0, b, d, e, o);
    @(negedge clk);
    dm_write = 1'b1;
    write_address_to_dm = 32'h20;
    data_to_dm = 32'hAAAA5555;
    @(posedge clk);
    #1;
    dm_write = 1'b0;
    checks++;
    if (dm_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_started: got busy=%b want 1", dm_busy);
    end
    #1;
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < L + 2; i++) begin
      @(posedge clk);
      #1;
      if (dm_done) dones++;
    end
    checks++;
    if (dones !== 0 || dm_busy !== 1'b0 || data_from_dm !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got dones=%0d busy=%b data=%h, want 0/0/0", dones, dm_busy,
               data_from_dm);
    end
    @(negedge clk);
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h20, 32'h0, b, d, e, o);
    checks++;
    if (d !== L || e !== 1'b0 || o !== 32'h0) begin
      errors++;
      $display("FAIL load_after_abort: got done_at=%0d err=%b data=%h, want %0d/0/0", d, e, o, L);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    dm_read = 1'b0;
    dm_write = 1'b0;
    read_address_to_dm = '0;
    write_address_to_dm = '0;
    data_to_dm = '0;
    #2;
    reset = 1'b1;
    #1;
    test_reset;
    test_store_load;
    test_boundary;
    test_misaligned;
    test_illegal_and_ignored;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
